// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice roller: FSM/mode enums, LFSR constants
// and the saturating adder used to form final_num.
package dice_pkg;

    typedef enum logic [1:0] {IDLE, ROLL, DONE} state_e;

    typedef enum logic [1:0] {
        MODE_NORMAL     = 2'b00,
        MODE_ADV        = 2'b01,
        MODE_DIS        = 2'b10,
        MODE_NORMAL_ALT = 2'b11
    } mode_e;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    // 64-bit working width comfortably covers NUM_BITS+SUM_W+1 for any sane config.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/dice_roller_if.sv
// Request/result bundle of the dice roller; master = requester/consumer side.
interface dice_roller_if #(
    parameter int MAX_DICE = 4,
    parameter int SIDES    = 20,
    parameter int NUM_BITS = 8
);
    localparam int CNT_W = $clog2(MAX_DICE + 1);
    localparam int SUM_W = $clog2(MAX_DICE * SIDES + 1);

    logic                       req_valid;
    logic                       req_ready;
    logic [CNT_W-1:0]           num_dice;
    logic signed [NUM_BITS-1:0] mod;
    logic signed [NUM_BITS-1:0] target;
    logic [1:0]                 mode;
    logic                       res_valid;
    logic                       res_ready;
    logic [SUM_W-1:0]           roll_sum;
    logic signed [NUM_BITS-1:0] final_num;
    logic                       hit;
    logic                       crit;
    logic                       fumble;

    modport master (
        output req_valid, num_dice, mod, target, mode, res_ready,
        input  req_ready, res_valid, roll_sum, final_num, hit, crit, fumble
    );

    modport slave (
        input  req_valid, num_dice, mod, target, mode, res_ready,
        output req_ready, res_valid, roll_sum, final_num, hit, crit, fumble
    );

endinterface

// File: rtl/dice_lfsr.sv
// 16-bit right-shifting Galois LFSR with synchronous load and advance enable.
module dice_lfsr
    import dice_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              adv,
    output logic [LFSR_W-1:0] state
);

    // An all-zero state would lock up, so a zero seed falls back to SEED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     state <= SEED;
        else if (load) state <= (seed == '0) ? SEED : seed;
        else if (adv)  state <= (state >> 1) ^ (state[0] ? LFSR_MASK : '0);
    end

endmodule

// File: rtl/dice_roller.sv
// Multi-die roller: rejection-sampled faces, saturating modifier, hit/crit/fumble.
// Define DICE_ADV_EN to honour advantage/disadvantage (two accepted faces per die).
module dice_roller
    import dice_pkg::*;
#(
    parameter int SIDES    = 20,
    parameter int MAX_DICE = 4,
    parameter int RAND_W   = 5,
    parameter int NUM_BITS = 8,
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_we,
    input  logic [LFSR_W-1:0] seed_i,
    dice_roller_if.slave      bus
);

    localparam int CNT_W = $clog2(MAX_DICE + 1);
    localparam int SUM_W = $clog2(MAX_DICE * SIDES + 1);
    localparam logic [RAND_W:0]  SIDES_V = (RAND_W + 1)'(SIDES);
    localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_DICE);

    state_e                     state, state_nx;
    logic [LFSR_W-1:0]          lfsr;
    logic [RAND_W-1:0]          cand, face;
    logic                       accept, keep;
    logic [CNT_W-1:0]           n_q, n_req, cnt, cnt_nx;
    logic [SUM_W-1:0]           sum, sum_nx;
    logic signed [NUM_BITS-1:0] mod_q, target_q, final_nx;
    logic                       crit_q, crit_nx, fumble_q, fumble_nx;
    logic signed [63:0]         sat_full;
    logic [SUM_W-1:0]           roll_sum_q;
    logic signed [NUM_BITS-1:0] final_q;
    logic                       hit_q, crit_o, fumble_o;
    logic                       unused_bits;

    dice_lfsr #(.SEED(SEED)) u_lfsr (
        .clk,
        .reset,
        .load  (seed_we && state == IDLE),
        .seed  (seed_i),
        .adv   (state == ROLL),
        .state (lfsr)
    );

    assign cand   = lfsr[RAND_W-1:0];
    assign accept = (cand != '0) && ({1'b0, cand} <= SIDES_V);
    assign n_req  = (bus.num_dice == '0)  ? CNT_W'(1) :
                    (bus.num_dice > MAX_V) ? MAX_V : bus.num_dice;

`ifdef DICE_ADV_EN
    mode_e             mode_q;
    logic              half, paired;
    logic [RAND_W-1:0] pend;

    assign paired = (mode_q == MODE_ADV) || (mode_q == MODE_DIS);

    // First accepted face of a pair is parked in pend; the second resolves the die.
    always_comb begin
        keep = accept && (!paired || half);
        face = cand;
        if (paired && half)
            face = ((mode_q == MODE_ADV) == (cand > pend)) ? cand : pend;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_NORMAL;
            half   <= 1'b0;
            pend   <= '0;
        end else if (state == IDLE) begin
            half <= 1'b0;
            if (bus.req_valid) mode_q <= mode_e'(bus.mode);
        end else if (state == ROLL && accept && paired) begin
            half <= !half;
            pend <= cand;
        end
    end
`else
    assign keep = accept;
    assign face = cand;
`endif

    assign unused_bits = ^{lfsr[LFSR_W-1:RAND_W], sat_full[63:NUM_BITS], bus.mode};

    always_comb begin
        state_nx  = state;
        sum_nx    = sum;
        cnt_nx    = cnt;
        crit_nx   = crit_q;
        fumble_nx = fumble_q;
        case (state)
            IDLE: if (bus.req_valid) state_nx = ROLL;
            ROLL: if (keep) begin
                sum_nx    = sum + SUM_W'(face);
                cnt_nx    = cnt + CNT_W'(1);
                crit_nx   = crit_q | ({1'b0, face} == SIDES_V);
                fumble_nx = fumble_q & (face == RAND_W'(1));
                if (cnt_nx == n_q) state_nx = DONE;
            end
            DONE: if (bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign sat_full = sat_add($signed({{(64 - SUM_W){1'b0}}, sum_nx}), 64'(mod_q), NUM_BITS);
    assign final_nx = sat_full[NUM_BITS-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q        <= '0;
            mod_q      <= '0;
            target_q   <= '0;
            sum        <= '0;
            cnt        <= '0;
            crit_q     <= 1'b0;
            fumble_q   <= 1'b0;
            roll_sum_q <= '0;
            final_q    <= '0;
            hit_q      <= 1'b0;
            crit_o     <= 1'b0;
            fumble_o   <= 1'b0;
        end else begin
            sum      <= sum_nx;
            cnt      <= cnt_nx;
            crit_q   <= crit_nx;
            fumble_q <= fumble_nx;
            if (state == IDLE && bus.req_valid) begin
                n_q      <= n_req;
                mod_q    <= bus.mod;
                target_q <= bus.target;
                sum      <= '0;
                cnt      <= '0;
                crit_q   <= 1'b0;
                fumble_q <= 1'b1;
            end
            // Results are captured once, on the last kept face, and held until next roll.
            if (state == ROLL && state_nx == DONE) begin
                roll_sum_q <= sum_nx;
                final_q    <= final_nx;
                hit_q      <= (final_nx >= target_q);
                crit_o     <= crit_nx;
                fumble_o   <= fumble_nx;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.res_valid = (state == DONE);
    assign bus.roll_sum  = roll_sum_q;
    assign bus.final_num = final_q;
    assign bus.hit       = hit_q;
    assign bus.crit      = crit_o;
    assign bus.fumble    = fumble_o;

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller: vector table plus stall and mid-roll reset sequences.
// With DICE_ADV_EN defined the table carries the advantage/disadvantage vectors.
module tb_dice_roller;
    import dice_pkg::*;

    typedef struct {
        logic [15:0] seed;
        int          n, md, tgt;
        logic [1:0]  mode;
        int          lat, sum, fin;
        bit          hit, crit, fum;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        seed_we = 1'b0;
    logic [15:0] seed_i = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        vecs[$];

    dice_roller_if #(.MAX_DICE(4), .SIDES(20), .NUM_BITS(8)) ifc ();

    dice_roller #(.SIDES(20), .MAX_DICE(4), .RAND_W(5), .NUM_BITS(8), .SEED(16'hACE1)) dut (
        .clk     (clk),
        .reset   (reset),
        .seed_we (seed_we),
        .seed_i  (seed_i),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic [15:0] s, int n, int md, int tgt, logic [1:0] m,
                                int lat, int sum, int fin, bit h, bit c, bit f);
        vec_t v;
        v.seed = s; v.n = n; v.md = md; v.tgt = tgt; v.mode = m;
        v.lat = lat; v.sum = sum; v.fin = fin; v.hit = h; v.crit = c; v.fum = f;
        return v;
    endfunction

    task automatic roll(input vec_t v, input bit ld, input string tag);
        int lat;
        ifc.req_valid = 1'b1;
        ifc.num_dice  = 3'(v.n);
        ifc.mod       = 8'(v.md);
        ifc.target    = 8'(v.tgt);
        ifc.mode      = v.mode;
        seed_we       = ld;
        seed_i        = v.seed;
        chk({tag, ".req_ready"}, int'(ifc.req_ready), 1);
        step();
        ifc.req_valid = 1'b0;
        seed_we       = 1'b0;
        ifc.num_dice  = 3'($urandom);
        ifc.mod       = 8'($urandom);
        ifc.target    = 8'($urandom);
        ifc.mode      = 2'($urandom);
        seed_i        = 16'($urandom);
        lat = 1;
        while (!ifc.res_valid && lat < 200) begin
            step();
            lat++;
        end
        chk({tag, ".latency"},   lat,                   v.lat);
        chk({tag, ".roll_sum"},  int'(ifc.roll_sum),    v.sum);
        chk({tag, ".final_num"}, int'(ifc.final_num),   v.fin);
        chk({tag, ".hit"},       int'(ifc.hit),         int'(v.hit));
        chk({tag, ".crit"},      int'(ifc.crit),        int'(v.crit));
        chk({tag, ".fumble"},    int'(ifc.fumble),      int'(v.fum));
        ifc.res_ready = 1'b1;
        step();
        ifc.res_ready = 1'b0;
        chk({tag, ".ready_after"}, int'(ifc.req_ready), 1);
        chk({tag, ".valid_after"}, int'(ifc.res_valid), 0);
    endtask

    initial begin
        int w;
        ifc.req_valid = 1'b0;
        ifc.res_ready = 1'b0;
        ifc.num_dice  = '0;
        ifc.mod       = '0;
        ifc.target    = '0;
        ifc.mode      = '0;

        //            seed     n  mod  tgt mode  lat sum  fin  h c f
        vecs.push_back(mk(16'h0020, 1,    0,   16, 2'b00,  3, 16,   16, 1, 0, 0));
        vecs.push_back(mk(16'h0001, 2,    0,   18, 2'b00,  9, 17,   17, 0, 0, 0));
        vecs.push_back(mk(16'h0001, 1,    0,   18, 2'b00,  2,  1,    1, 0, 0, 1));
        vecs.push_back(mk(16'h0014, 1,  127,  127, 2'b00,  2, 20,  127, 1, 1, 0));
        vecs.push_back(mk(16'h0014, 1, -128, -127, 2'b00,  2, 20, -108, 1, 1, 0));
        vecs.push_back(mk(16'h0014, 0,    0,   21, 2'b00,  2, 20,   20, 0, 1, 0));
        vecs.push_back(mk(16'h0001, 7,    0,   40, 2'b00, 11, 45,   45, 1, 1, 0));
        vecs.push_back(mk(16'h0000, 1,   -5,   -4, 2'b00,  2,  1,   -4, 1, 0, 1));
`ifdef DICE_ADV_EN
        vecs.push_back(mk(16'h0001, 1,    0,   16, 2'b01,  9, 16,   16, 1, 0, 0));
        vecs.push_back(mk(16'h0001, 1,    0,   16, 2'b10,  9,  1,    1, 0, 0, 1));
`else
        vecs.push_back(mk(16'h0001, 1,    0,   18, 2'b01,  2,  1,    1, 0, 0, 1));
`endif

        // Reset state, sampled while reset is held.
        step();
        chk("rst.req_ready", int'(ifc.req_ready), 1);
        chk("rst.res_valid", int'(ifc.res_valid), 0);
        chk("rst.roll_sum",  int'(ifc.roll_sum),  0);
        chk("rst.final_num", int'(ifc.final_num), 0);
        chk("rst.hit",       int'(ifc.hit),       0);
        chk("rst.crit",      int'(ifc.crit),      0);
        chk("rst.fumble",    int'(ifc.fumble),    0);
        reset = 1'b0;
        step();

        foreach (vecs[i]) roll(vecs[i], 1'b1, $sformatf("vec%0d", i));

        // Hold the result for 10 cycles while a new request and seed load are offered.
        ifc.req_valid = 1'b1; ifc.num_dice = 3'd1; ifc.mod = '0; ifc.target = '0; ifc.mode = '0;
        seed_we = 1'b1; seed_i = 16'h0014;
        step();
        ifc.req_valid = 1'b0; seed_we = 1'b0;
        w = 0;
        while (!ifc.res_valid && w < 50) begin step(); w++; end
        chk("stall.reached_done", int'(ifc.res_valid), 1);
        for (int i = 0; i < 10; i++) begin
            ifc.req_valid = 1'b1; seed_we = 1'b1; seed_i = 16'h0001;
            chk($sformatf("stall%0d.res_valid", i), int'(ifc.res_valid), 1);
            chk($sformatf("stall%0d.roll_sum", i),  int'(ifc.roll_sum),  20);
            chk($sformatf("stall%0d.req_ready", i), int'(ifc.req_ready), 0);
            step();
        end
        ifc.req_valid = 1'b0; seed_we = 1'b0;
        ifc.res_ready = 1'b1;
        step();
        ifc.res_ready = 1'b0;
        step();
        chk("stall.no_spurious_roll", int'(ifc.res_valid), 0);
        // LFSR advanced once from 0x0014 to 0x000A; the seed offered in DONE must not load.
        roll(mk(16'h0000, 1, 0, 0, 2'b00, 2, 10, 10, 1, 0, 0), 1'b0, "after_stall");

        // Reset in the middle of a long roll.
        ifc.req_valid = 1'b1; ifc.num_dice = 3'd2; ifc.mod = '0; ifc.target = '0; ifc.mode = '0;
        seed_we = 1'b1; seed_i = 16'h0001;
        step();
        ifc.req_valid = 1'b0; seed_we = 1'b0;
        step();
        step();
        chk("midroll.busy", int'(ifc.req_ready), 0);
        reset = 1'b1;
        #1;
        chk("midroll.rst_valid", int'(ifc.res_valid), 0);
        chk("midroll.rst_ready", int'(ifc.req_ready), 1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("midroll%0d.res_valid", i), int'(ifc.res_valid), 0);
        end
        // SEED 0xACE1 gives candidate 1 first.
        roll(mk(16'h0000, 1, 0, 0, 2'b00, 2, 1, 1, 1, 0, 1), 1'b0, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
